// File: rtl/serial_mult_q.sv
// Bit-serial sign-magnitude multiplier: a latched neuron operand times a weight streamed MSB first,
// rounded half-up back to the neuron format with saturation.
module serial_mult_q #(
    parameter  int INT_W      = 5,
    parameter  int FRAC_W     = 10,
    parameter  int WGT_INT_W  = 5,
    parameter  int WGT_FRAC_W = 10,
    localparam int DATA_W     = 1 + INT_W + FRAC_W,
    localparam int WGT_W      = 1 + WGT_INT_W + WGT_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_neuron,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic              w_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);
    localparam int MAG_W = DATA_W - 1;
    localparam int ACC_W = MAG_W + WGT_W - 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = (WGT_W > 1) ? $clog2(WGT_W) : 1;
    localparam logic [SUM_W-1:0] RND_INC = SUM_W'(1) << (WGT_FRAC_W - 1);
    localparam logic [SUM_W-1:0] MAG_MAX = (SUM_W'(1) << MAG_W) - SUM_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

    state_t             state, state_nxt;
    logic               n_sign, w_sign;
    logic [MAG_W-1:0]   n_mag;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               w_fire, last_bit;
    logic [SUM_W-1:0]   sum, rnd;
    logic               ovf, res_sign;
    logic [MAG_W-1:0]   res_mag;

    assign w_fire   = w_valid && w_ready;
    assign last_bit = (cnt == CNT_W'(WGT_W - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w_ready   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                w_ready = 1'b1;
                if (w_valid && last_bit) state_nxt = ROUND;
            end
            ROUND: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator is wide enough for the full product; only ROUND narrows it.
    always_comb begin
        sum      = {1'b0, acc} + RND_INC;
        rnd      = sum >> WGT_FRAC_W;
        ovf      = (rnd > MAG_MAX);
        res_mag  = ovf ? {MAG_W{1'b1}} : rnd[MAG_W-1:0];
        res_sign = (n_sign ^ w_sign) & (|res_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_sign   <= 1'b0;
            n_mag    <= '0;
            w_sign   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                n_sign <= in_neuron[DATA_W-1];
                n_mag  <= in_neuron[MAG_W-1:0];
                acc    <= '0;
                cnt    <= '0;
            end
            // First streamed bit is the weight sign; the rest are magnitude, MSB first.
            if (w_fire) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == '0) w_sign <= w_bit;
                else           acc    <= (acc << 1) + (w_bit ? ACC_W'(n_mag) : ACC_W'(0));
            end
            if (state == ROUND) begin
                out_data <= {res_sign, res_mag};
                out_ovf  <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_serial_mult_q.sv
// Randomized scoreboard bench for serial_mult_q against an integer-arithmetic product model.
module tb_serial_mult_q;
    localparam int INT_W = 5, FRAC_W = 10, WGT_INT_W = 5, WGT_FRAC_W = 10;
    localparam int DATA_W = 1 + INT_W + FRAC_W;
    localparam int WGT_W  = 1 + WGT_INT_W + WGT_FRAC_W;
    localparam int MAG_W  = DATA_W - 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              ovf;
        int                t;
        int                lat;
        int                bp;
    } exp_t;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, w_valid, w_ready, w_bit, out_valid, out_ready, out_ovf;
    logic [DATA_W-1:0] in_neuron, out_data;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t q[$];

    serial_mult_q #(.INT_W(INT_W), .FRAC_W(FRAC_W), .WGT_INT_W(WGT_INT_W), .WGT_FRAC_W(WGT_FRAC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_neuron(in_neuron),
        .w_valid(w_valid), .w_ready(w_ready), .w_bit(w_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact product, round half-up, saturate, no negative zero.
    task automatic model(input logic [DATA_W-1:0] n, input logic [WGT_W-1:0] w,
                         output logic [DATA_W-1:0] d, output logic ovf);
        longint p, r, mx;
        p   = longint'(n[MAG_W-1:0]) * longint'(w[WGT_W-2:0]);
        r   = (p + (longint'(1) << (WGT_FRAC_W - 1))) / (longint'(1) << WGT_FRAC_W);
        mx  = (longint'(1) << MAG_W) - 1;
        ovf = (r > mx);
        if (ovf) r = mx;
        d = {(n[DATA_W-1] ^ w[WGT_W-1]) && (r != 0), MAG_W'(r)};
    endtask

    task automatic run_op(input logic [DATA_W-1:0] n, input logic [WGT_W-1:0] w,
                          input int stall_at, input int stall_len, input int bp);
        exp_t e;
        int   guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        chk("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        in_neuron = n;
        model(n, w, e.data, e.ovf);
        e.t   = cyc;
        e.lat = WGT_W + 2 + ((stall_at >= 0) ? stall_len : 0);
        e.bp  = bp;
        q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        in_neuron = DATA_W'($urandom);
        for (int i = 0; i < WGT_W; i++) begin
            if (i == stall_at)
                repeat (stall_len) begin w_valid = 1'b0; w_bit = 1'($urandom); @(negedge clk); end
            w_valid = 1'b1;
            w_bit   = w[WGT_W-1-i];
            @(negedge clk);
        end
        // Junk on the weight port outside SHIFT must be ignored.
        w_valid = 1'($urandom);
        w_bit   = 1'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !reset) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.t, e.lat);
                    chk("out_data", out_data, e.data);
                    chk("out_ovf", out_ovf, e.ovf);
                    repeat (e.bp) begin
                        @(negedge clk);
                        chk("hold_valid", out_valid, 1);
                        chk("hold_data", out_data, e.data);
                        chk("hold_in_ready", in_ready, 0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'($urandom);
                    chk("post_hs_in_ready", in_ready, 1);
                    chk("post_hs_out_valid", out_valid, 0);
                    out_ready = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        logic [DATA_W-1:0] n;
        logic [WGT_W-1:0]  w;
        int guard;
        reset = 1'b1; in_valid = 1'b0; in_neuron = '0; w_valid = 1'b1; w_bit = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);

        run_op(16'h0400, 16'h0400, -1, 0, 0);   // unity
        run_op(16'h8600, 16'h0800, -1, 0, 1);   // -1.5 * 2.0
        run_op(16'h5000, 16'h1000, -1, 0, 0);   // saturate positive
        run_op(16'hD000, 16'h1000, -1, 0, 2);   // saturate negative
        run_op(16'h0001, 16'h0200, -1, 0, 0);   // rounds up to 1 LSB
        run_op(16'h8000, 16'h0400, -1, 0, 0);   // negative zero suppressed
        run_op(16'h0400, 16'h0400, 5, 3, 0);    // weight stall
        run_op(16'h0400, 16'h0400, -1, 0, 4);   // output backpressure

        // Reset in the middle of a weight stream, with handshakes active.
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        in_valid = 1'b1; in_neuron = 16'h0400;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin w_valid = 1'b1; w_bit = 1'($urandom); @(negedge clk); end
        reset = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; w_valid = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_w_ready", w_ready, 0);
        chk("midrst_out_data", out_data, 0);
        run_op(16'h0400, 16'h0400, -1, 0, 0);

        for (int k = 0; k < 30; k++) begin
            n = DATA_W'($urandom);
            w = WGT_W'($urandom);
            if (k % 2 == 0) begin
                n[MAG_W-1:FRAC_W] = '0;
                w[WGT_W-2:WGT_FRAC_W+2] = '0;
            end
            run_op(n, w, (k % 3 == 0) ? int'($urandom_range(0, WGT_W - 1)) : -1,
                   int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        guard = 0;
        while (q.size() != 0 && guard < 500) begin @(negedge clk); guard++; end
        chk("drain_queue", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_mult_q.md
SERIAL_MULT_Q -- requirements
Module: serial_mult_q

Interface
REQ-001 Parameter INT_W, default 5, integer bits of the neuron and result magnitude.
REQ-002 Parameter FRAC_W, default 10, fraction bits of the neuron and result magnitude.
REQ-003 Parameter WGT_INT_W, default 5, integer bits of the weight magnitude.
REQ-004 Parameter WGT_FRAC_W, default 10, fraction bits of the weight magnitude; the legal range is 1 or greater.
REQ-005 The derived widths SHALL be DATA_W = 1+INT_W+FRAC_W and WGT_W = 1+WGT_INT_W+WGT_FRAC_W; all values are sign-magnitude with the sign in the MSB.
REQ-006 The block uses one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  neuron operand offered.
REQ-010 in_ready  out  1  block can accept a neuron operand.
REQ-011 in_neuron  in  DATA_W  neuron operand.
REQ-012 w_valid  in  1  w_bit is valid this cycle.
REQ-013 w_ready  out  1  block is consuming weight bits.
REQ-014 w_bit  in  1  serial weight bit.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_data  out  DATA_W  signed-magnitude product in the neuron format.
REQ-018 out_ovf  out  1  the magnitude saturated; qualified by out_valid.

Function
REQ-019 The FSM SHALL have four states: IDLE, SHIFT, ROUND and OUT.
REQ-020 FSM transitions:
- IDLE to SHIFT on in_valid and in_ready.
- SHIFT to ROUND on consumption of the WGT_W-th weight bit.
- ROUND to OUT unconditionally.
- OUT to IDLE on out_valid and out_ready.
REQ-021 in_ready SHALL be 1 only in IDLE, w_ready only in SHIFT, and out_valid only in OUT.
REQ-022 On acceptance, the block SHALL latch the neuron sign and the DATA_W-1-bit magnitude, clear the accumulator, and clear the bit counter.
REQ-023 A weight bit SHALL be consumed only on a cycle with w_valid and w_ready; w_valid outside SHIFT SHALL be ignored.
REQ-024 Weight bits arrive MSB first: the first consumed bit is the weight sign, and the next WGT_W-1 bits are the magnitude, MSB first.
REQ-025 Each consumed magnitude bit b SHALL update the accumulator: acc <= (acc<<1) + (b ? neuron_mag : 0).
REQ-026 The accumulator width SHALL be (DATA_W-1)+(WGT_W-1) with no truncation during accumulation.
REQ-027 A cycle in SHIFT with w_valid=0 SHALL hold acc, counter and sign unchanged (stall), with no bound on stall length.
REQ-028 The ROUND state SHALL compute the magnitude as (acc + 2^(WGT_FRAC_W-1)) >> WGT_FRAC_W, i.e. round-half-up to FRAC_W fraction bits.
REQ-029 If the rounded magnitude exceeds 2^(DATA_W-1)-1, the magnitude SHALL become 2^(DATA_W-1)-1 and out_ovf=1; otherwise out_ovf=0.
REQ-030 The result sign SHALL be neuron_sign XOR weight_sign, forced to 0 when the final magnitude is 0 (no negative zero).
REQ-031 out_data and out_ovf SHALL be registered at the end of ROUND and held stable in OUT until the handshake completes.
REQ-032 Latency with continuous w_valid: acceptance at cycle T, weight bits consumed at T+1..T+WGT_W, and out_valid=1 from cycle T+WGT_W+2; each stall cycle adds 1.
REQ-033 After out handshake at cycle U, in_ready SHALL be 1 at U+1; there is no overlap of consecutive operations.
REQ-034 The block SHALL support any parameter set meeting REQ-004 without changing RTL.

Reset
REQ-035 When reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, abandoning any operation in progress.
REQ-036 When reset=1 at a clock edge, acc, counter and the latched operands SHALL be cleared.
REQ-037 After reset: out_data=0, out_ovf=0, out_valid=0, w_ready=0, in_ready=1 in the cycle after reset deasserts.
REQ-038 Reset SHALL take priority over every handshake in the same cycle.

Verification (defaults; 1.0 = 0x0400)
REQ-039 Unity: in_neuron 0x0400 with weight stream 0x0400 and continuous w_valid -> out_data 0x0400, out_ovf 0, out_valid at T+18.
REQ-040 Sign: in_neuron 0x8600 (-1.5) with weight 0x0800 (2.0) -> out_data 0x8C00, out_ovf 0.
REQ-041 Saturation: in_neuron 0x5000 (20.0) with weight 0x1000 (4.0) -> out_data 0x7FFF, out_ovf 1; the same operands negated -> out_data 0xFFFF.
REQ-042 Rounding and zero:
- in_neuron 0x0001 with weight 0x0200 -> out_data 0x0001.
- in_neuron 0x8000 with weight 0x0400 -> out_data 0x0000.
REQ-043 Stall and backpressure, 1.0 x 1.0:
- w_valid low for 3 cycles after bit 5 -> out_valid at T+21, same data.
- out_ready low for 4 cycles -> out_data held and in_ready=0 until the handshake.
REQ-044 Reset mid-SHIFT after 7 bits -> next cycle in_ready=1 and out_valid=0; a new 1.0 x 1.0 run -> 0x0400.
